// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display/CPU arbiter for the shared 8K x 16 video RAM
// Optional byte lanes: define VRAM_ARB_BYTE_EN to add cpu_be / mem_be_n.
// Ports:
//   clk, rstn                          clock, asynchronous active-low reset
//   disp_req, disp_addr                display fetch strobe and word address
//   disp_data, disp_valid, disp_ovf    fetched word, valid pulse, sticky lost-fetch flag
//   cpu_req, cpu_we, cpu_addr          CPU level request, direction, word address
//   cpu_wdata, cpu_rdata               CPU write data, read data (valid with cpu_ack)
//   cpu_ack, cpu_err                   completion pulse, timed-out flag (with cpu_ack)
//   cpu_be, mem_be_n                   byte lanes (VRAM_ARB_BYTE_EN only)
//   mem_addr, mem_dout, mem_dout_en    VRAM address, write data, data bus drive enable
//   mem_din, mem_oe_n, mem_we_n        VRAM read data, output / write enables (active low)
module vram_arbiter #(
  parameter int ACC_CYC = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        disp_req,
  input  logic [12:0] disp_addr,
  output logic [15:0] disp_data,
  output logic        disp_valid,
  output logic        disp_ovf,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
`ifdef VRAM_ARB_BYTE_EN
  input  logic [1:0]  cpu_be,
  output logic [1:0]  mem_be_n,
`endif
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [12:0] mem_addr,
  output logic [15:0] mem_dout,
  output logic        mem_dout_en,
  input  logic [15:0] mem_din,
  output logic        mem_oe_n,
  output logic        mem_we_n
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DRD  = 3'd1;
  localparam logic [2:0] S_CRD  = 3'd2;
  localparam logic [2:0] S_CWS  = 3'd3;
  localparam logic [2:0] S_CWR  = 3'd4;
  localparam logic [2:0] S_CWH  = 3'd5;

  localparam int AW = $clog2(ACC_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] ACC_LAST = AW'(ACC_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [AW-1:0] acc_cnt;
  logic [TW-1:0] wait_cnt;
  logic          disp_pend;
  logic [12:0]   pend_addr;
  logic          ack_d;

  logic acc_last, consume, disp_go, cpu_live, cpu_grant, cpu_wait, wr_we_n;

  assign acc_last  = (acc_cnt == ACC_LAST);
  assign consume   = (state == S_DRD) && acc_last;
  assign disp_go   = disp_pend || disp_req;
  // cpu_req is still high while the CPU reacts to cpu_ack; mask it for the ack cycle and the one after.
  assign cpu_live  = cpu_req && !cpu_ack && !ack_d;
  assign cpu_grant = (state == S_IDLE) && !disp_go && cpu_live;
  // The CPU is waiting whenever it is live but the memory is idle-to-display or busy with a fetch.
  assign cpu_wait  = cpu_live && !cpu_grant && ((state == S_IDLE) || (state == S_DRD));

`ifdef VRAM_ARB_BYTE_EN
  // A write with no lanes enabled runs the full handshake but never strobes the RAM.
  assign wr_we_n = &mem_be_n;
`else
  assign wr_we_n = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      acc_cnt     <= '0;
      wait_cnt    <= '0;
      disp_pend   <= 1'b0;
      pend_addr   <= '0;
      ack_d       <= 1'b0;
      disp_data   <= '0;
      disp_valid  <= 1'b0;
      disp_ovf    <= 1'b0;
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
      cpu_err     <= 1'b0;
      mem_addr    <= '0;
      mem_dout    <= '0;
      mem_dout_en <= 1'b0;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
`ifdef VRAM_ARB_BYTE_EN
      mem_be_n    <= 2'b11;
`endif
    end else begin
      disp_valid <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      ack_d      <= cpu_ack;

      // One-deep fetch latch; a slot freed this cycle may be refilled by a new strobe.
      if (disp_req) begin
        if (disp_pend && !consume) begin
          disp_ovf <= 1'b1;
        end else begin
          disp_pend <= 1'b1;
          pend_addr <= disp_addr;
        end
      end else if (consume) begin
        disp_pend <= 1'b0;
      end

      if (cpu_wait) begin
        if (wait_cnt == TO_LAST) begin
          wait_cnt <= '0;
          cpu_ack  <= 1'b1;
          cpu_err  <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + TW'(1);
        end
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        S_IDLE: begin
          acc_cnt <= '0;
          if (disp_go) begin
            state    <= S_DRD;
            mem_addr <= disp_pend ? pend_addr : disp_addr;
            mem_oe_n <= 1'b0;
`ifdef VRAM_ARB_BYTE_EN
            mem_be_n <= 2'b00;
`endif
          end else if (cpu_grant) begin
            mem_addr <= cpu_addr;
            if (!cpu_we) begin
              state    <= S_CRD;
              mem_oe_n <= 1'b0;
`ifdef VRAM_ARB_BYTE_EN
              mem_be_n <= 2'b00;
`endif
            end else begin
              state       <= S_CWS;
              mem_dout    <= cpu_wdata;
              mem_dout_en <= 1'b1;
`ifdef VRAM_ARB_BYTE_EN
              mem_be_n    <= ~cpu_be;
`endif
            end
          end
        end
        S_DRD, S_CRD: begin
          if (acc_last) begin
            state    <= S_IDLE;
            mem_oe_n <= 1'b1;
`ifdef VRAM_ARB_BYTE_EN
            mem_be_n <= 2'b11;
`endif
            if (state == S_DRD) begin
              disp_data  <= mem_din;
              disp_valid <= 1'b1;
            end else begin
              cpu_rdata <= mem_din;
              cpu_ack   <= 1'b1;
            end
          end else begin
            acc_cnt <= acc_cnt + AW'(1);
          end
        end
        S_CWS: begin
          state    <= S_CWR;
          acc_cnt  <= '0;
          mem_we_n <= wr_we_n;
        end
        S_CWR: begin
          if (acc_last) begin
            state    <= S_CWH;
            mem_we_n <= 1'b1;
            cpu_ack  <= 1'b1;
          end else begin
            acc_cnt <= acc_cnt + AW'(1);
          end
        end
        S_CWH: begin
          state       <= S_IDLE;
          mem_dout_en <= 1'b0;
`ifdef VRAM_ARB_BYTE_EN
          mem_be_n    <= 2'b11;
`endif
        end
        default: begin
          state       <= S_IDLE;
          mem_oe_n    <= 1'b1;
          mem_we_n    <= 1'b1;
          mem_dout_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single 8K x 16 video RAM between the display scan-out fetch path and the host CPU bus.
- Display fetches have absolute priority so the fetch latency seen by the display controller is bounded.
- CPU reads and writes fill the idle memory cycles, with a wait timeout.
- Sits between the display controller's memory port and the external VRAM pins in the display top level.

Parameters:
- ACC_CYC, 2: memory access length in clk cycles (>=1); read data sampled on the last access cycle.
- TIMEOUT, 255: maximum cycles a CPU request waits for a grant before it is errored (>=1).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- disp_req  in  1  one-cycle fetch strobe from display controller
- disp_addr  in  13  fetch word address, valid with disp_req
- disp_data  out  16  fetched word
- disp_valid  out  1  one-cycle pulse, disp_data valid
- disp_ovf  out  1  sticky: fetch request lost
- cpu_req  in  1  level request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  13  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_rdata  out  16  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  with cpu_ack: request timed out, no access done
- mem_addr  out  13  VRAM address
- mem_dout  out  16  VRAM write data
- mem_dout_en  out  1  drive enable for the VRAM data bus
- mem_din  in  16  VRAM read data
- mem_oe_n  out  1  VRAM output enable, active low
- mem_we_n  out  1  VRAM write enable, active low

Behaviour:
- Reset, asynchronous on rstn low:
  - State IDLE; all counters 0; disp_pend=0.
  - mem_oe_n=1, mem_we_n=1, mem_dout_en=0, mem_addr=0, mem_dout=0.
  - disp_data=0, disp_valid=0, disp_ovf=0, cpu_rdata=0, cpu_ack=0, cpu_err=0.
  - Reset mid-access aborts the access immediately; any pending request is discarded.
- Display request latch:
  - disp_req sets a one-deep pending flag and captures disp_addr.
  - disp_req while the flag is already set (and not consumed that cycle) sets disp_ovf; the later request is dropped.
  - disp_ovf clears only on reset.
- States:
  - IDLE:
    - If disp_pend (or disp_req this cycle) -> DRD.
    - Else if cpu_req and !cpu_we -> CRD.
    - Else if cpu_req and cpu_we -> CWS.
  - DRD:
    - ACC_CYC cycles with mem_addr=pending address and mem_oe_n=0.
    - mem_din is captured on the last edge.
    - disp_valid pulses the following cycle; disp_pend clears; -> IDLE.
  - CRD:
    - Same timing as DRD using cpu_addr.
    - cpu_rdata captured on the last edge; cpu_ack pulses the next cycle; -> IDLE.
  - CWS:
    - 1 setup cycle: mem_addr, mem_dout and mem_dout_en=1; mem_we_n=1.
    - -> CWR.
  - CWR:
    - ACC_CYC cycles with mem_we_n=0 and data driven.
    - -> CWH.
  - CWH:
    - 1 hold cycle: we_n=1 while data is still driven; cpu_ack pulses.
    - mem_dout_en drops on exit; -> IDLE.
- Priority and latency:
  - No access is preempted.
  - A display request from idle gives disp_valid exactly ACC_CYC+1 cycles after disp_req.
  - Worst case behind a CPU write is 2*ACC_CYC+3.
  - A display request and a CPU request arriving together: display goes first.
- CPU timeout:
  - The wait counter increments each cycle cpu_req is high while the arbiter is not serving the CPU.
  - It clears on grant or ack.
  - At the count reaching TIMEOUT: cpu_ack=1 and cpu_err=1 for one cycle, no memory access; counter clears.
  - cpu_req must drop after any ack before a new request is taken.
  - The arbiter ignores cpu_req in the cycle after cpu_ack.
- Widths:
  - Counters are sized to hold TIMEOUT and ACC_CYC; no wrap-around is reachable.
- mem_oe_n and mem_we_n are never low in the same cycle.
- mem_dout_en is never high while mem_oe_n=0.

Optional Feature:
- Macro: VRAM_ARB_BYTE_EN.
- When defined:
  - Adds input cpu_be[1:0] (bit1 = upper byte, bit0 = lower byte) and output mem_be_n[1:0].
  - mem_be_n = ~cpu_be during CWS/CWR/CWH; 2'b00 during reads; 2'b11 at reset and in IDLE.
  - A CPU write with cpu_be=2'b00 completes with cpu_ack, but mem_we_n stays high.
- When undefined: no byte-lane ports; all writes are full 16-bit words.

Test Plan:
- Reset with ACC_CYC=2: disp_req with disp_addr=13'h0100 and mem_din=16'hBEEF -> disp_valid 3 cycles later with disp_data=16'hBEEF; mem_oe_n low exactly 2 cycles.
- CPU write to 13'h1FFF with data 16'h5A5A from idle -> mem_we_n low 2 cycles after 1 setup cycle; cpu_ack on the hold cycle, 4 cycles after the request; mem_dout_en high for 4 cycles.
- disp_req and a CPU read in the same cycle -> display served first (disp_valid at +3); then CPU read, cpu_ack at +6 with cpu_rdata equal to mem_din.
- Second disp_req while the first is still pending (CPU write in progress) -> disp_ovf=1 and stays 1; first fetch still returns within 2*ACC_CYC+3 cycles.
- TIMEOUT=4, display requests back-to-back every 3 cycles, cpu_req held -> cpu_ack with cpu_err=1 after 4 waiting cycles; no mem_we_n or CPU-address access.
- Assert rstn low during CWR -> mem_we_n=1, mem_dout_en=0, cpu_ack=0 immediately; after release, IDLE with no pending requests.
